// File: rtl/tail_light_sequencer_if.sv
// Request/lamp bundle between the turn-signal controls and the tail-light sequencer.
// master: drives left/right/hazard (and brake when TLS_BRAKE_EN is defined), observes lamps and step.
// slave : the sequencer; samples the requests, drives Lcba, Rabc and step.
interface tail_light_sequencer_if;
   logic       left;
   logic       right;
   logic       hazard;
`ifdef TLS_BRAKE_EN
   logic       brake;
`endif
   logic [2:0] Lcba;    // {Lc,Lb,La}
   logic [2:0] Rabc;    // {Ra,Rb,Rc}
   logic       step;

   modport master (
      output left,
      output right,
      output hazard,
`ifdef TLS_BRAKE_EN
      output brake,
`endif
      input  Lcba,
      input  Rabc,
      input  step
   );

   modport slave (
      input  left,
      input  right,
      input  hazard,
`ifdef TLS_BRAKE_EN
      input  brake,
`endif
      output Lcba,
      output Rabc,
      output step
   );
endinterface

// File: rtl/tail_light_sequencer.sv
// Thunderbird-style tail-light sequencer: turn/hazard requests -> 3-lamp-per-side patterns.
// Latency: state and lamps advance on prescaler ticks (every TICK_DIV clocks); lamps registered from next state.
// Backpressure: none; level requests are sampled only on tick edges, downstream dimmer always accepts.
//
// Ports: clk (rising edge), reset (synchronous, active-high), bus (slave modport):
//    left/right/hazard level requests in, Lcba/Rabc lamp bits out, step one-clock pulse per sequence step.
// Optional: define TLS_BRAKE_EN to add bus.brake, which ORs a steady-on override into the
//    lamps on every clock (one clock latency) without touching the sequence state.
module tail_light_sequencer #(
   parameter int TICK_DIV = 12500000
) (
   input  logic                          clk,
   input  logic                          reset,
   tail_light_sequencer_if.slave         bus
);

   localparam int CNT_W = $clog2(TICK_DIV) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      L1   = 3'd1,
      L2   = 3'd2,
      L3   = 3'd3,
      R1   = 3'd4,
      R2   = 3'd5,
      R3   = 3'd6,
      HAZ  = 3'd7
   } state_t;

   logic [CNT_W-1:0] count;
   logic             tick;
   state_t           state;
   state_t           next_state;
   logic [2:0]       lcba_nxt;
   logic [2:0]       rabc_nxt;

   // ---------------------------------------------------------------
   // Step-rate prescaler; tick is the last count of each period
   // ---------------------------------------------------------------
   assign tick = (count == CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   // ---------------------------------------------------------------
   // State register, plus the lamp/step registers fed from next state
   // so lamps change on the same edge as the state.
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         bus.Lcba <= 3'b000;
         bus.Rabc <= 3'b000;
         bus.step <= 1'b0;
      end else begin
         state    <= next_state;
         bus.Lcba <= lcba_nxt;
         bus.Rabc <= rabc_nxt;
         bus.step <= tick;
      end
   end

   // ---------------------------------------------------------------
   // Next-state logic; requests only matter on tick edges
   // ---------------------------------------------------------------
   always_comb begin
      next_state = state;
      if (tick) begin
         unique case (state)
            IDLE: begin
               // Both turn requests at once is treated as a hazard request.
               if (bus.hazard || (bus.left && bus.right)) begin
                  next_state = HAZ;
               end else if (bus.left) begin
                  next_state = L1;
               end else if (bus.right) begin
                  next_state = R1;
               end else begin
                  next_state = IDLE;
               end
            end
            // A started pattern runs to completion; only hazard may cut it
            // short, and only before the final all-on step.
            L1:      next_state = bus.hazard ? HAZ : L2;
            L2:      next_state = bus.hazard ? HAZ : L3;
            L3:      next_state = IDLE;
            R1:      next_state = bus.hazard ? HAZ : R2;
            R2:      next_state = bus.hazard ? HAZ : R3;
            R3:      next_state = IDLE;
            // HAZ always returns through IDLE, so a held hazard blinks.
            HAZ:     next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Output decode of next state (Moore), with optional brake override
   // ---------------------------------------------------------------
   always_comb begin
      lcba_nxt = 3'b000;
      rabc_nxt = 3'b000;
      unique case (next_state)
         IDLE: begin lcba_nxt = 3'b000; rabc_nxt = 3'b000; end
         L1:   begin lcba_nxt = 3'b001; rabc_nxt = 3'b000; end
         L2:   begin lcba_nxt = 3'b011; rabc_nxt = 3'b000; end
         L3:   begin lcba_nxt = 3'b111; rabc_nxt = 3'b000; end
         R1:   begin lcba_nxt = 3'b000; rabc_nxt = 3'b100; end
         R2:   begin lcba_nxt = 3'b000; rabc_nxt = 3'b110; end
         R3:   begin lcba_nxt = 3'b000; rabc_nxt = 3'b111; end
         HAZ:  begin lcba_nxt = 3'b111; rabc_nxt = 3'b111; end
         default: begin lcba_nxt = 3'b000; rabc_nxt = 3'b000; end
      endcase
`ifdef TLS_BRAKE_EN
      // Brake lights the side that is not signalling; the turning side
      // keeps its pattern so the turn stays readable while braking.
      if (bus.brake) begin
         unique case (next_state)
            L1, L2, L3: rabc_nxt = 3'b111;
            R1, R2, R3: lcba_nxt = 3'b111;
            default: begin
               lcba_nxt = 3'b111;
               rabc_nxt = 3'b111;
            end
         endcase
      end
`endif
   end

endmodule

// File: tb/tb_tail_light_sequencer.sv
module tb_tail_light_sequencer;

   localparam int TD = 4;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   tail_light_sequencer_if bus ();

   tail_light_sequencer #(.TICK_DIV(TD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: which side is signalling and how many lamps are lit.
   // side: 0 none, 1 left, 2 right, 3 hazard; lit: lamps on for left/right (1..3).
   int         m_div;
   int         m_side;
   int         m_lit;
   logic       m_step;
   logic [2:0] m_l;
   logic [2:0] m_r;

   function automatic logic [2:0] ones(int n);
      logic [2:0] v;
      v = 3'(( 1 << n) - 1);
      return v;
   endfunction

   // Advance the model one clock edge using the inputs seen at that edge.
   task automatic model_edge();
      logic l, r, h, b, tk;
      l = bus.left; r = bus.right; h = bus.hazard; b = 1'b0;
`ifdef TLS_BRAKE_EN
      b = bus.brake;
`endif
      if (reset) begin
         m_div = 0; m_side = 0; m_lit = 0; m_step = 1'b0;
         m_l = 3'b000; m_r = 3'b000;
         return;
      end
      tk     = (m_div == TD - 1);
      m_div  = tk ? 0 : m_div + 1;
      m_step = tk;
      if (tk) begin
         if (m_side == 0) begin
            if (h || (l && r)) m_side = 3;
            else if (l) begin m_side = 1; m_lit = 1; end
            else if (r) begin m_side = 2; m_lit = 1; end
         end else if (m_side == 3) begin
            m_side = 0;
         end else if (h && m_lit < 3) begin
            m_side = 3;
         end else if (m_lit == 3) begin
            m_side = 0;
         end else begin
            m_lit = m_lit + 1;
         end
      end
      m_l = 3'b000; m_r = 3'b000;
      case (m_side)
         1: m_l = ones(m_lit);
         2: m_r = 3'(ones(m_lit) << (3 - m_lit));
         3: begin m_l = 3'b111; m_r = 3'b111; end
         default: ;
      endcase
      if (b) begin
         if (m_side != 1) m_l = 3'b111;
         if (m_side != 2) m_r = 3'b111;
      end
   endtask

   task automatic chk(string tag, logic [2:0] obs, logic [2:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // One clock: edge, update model, then compare away from the edge.
   task automatic clock_n(int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_edge();
         #1;
         chk("lcba", bus.Lcba, m_l);
         chk("rabc", bus.Rabc, m_r);
         chk("step", {2'b00, bus.step}, {2'b00, m_step});
      end
   endtask

   task automatic set_in(logic l, logic r, logic h, logic b);
      bus.left = l; bus.right = r; bus.hazard = h;
`ifdef TLS_BRAKE_EN
      bus.brake = b;
`endif
   endtask

   // Reset for 3 clocks with the given requests held; reset released after.
   task automatic do_reset(logic l, logic r, logic h);
      reset = 1'b1;
      set_in(l, r, h, 1'b0);
      clock_n(3);
      reset = 1'b0;
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      m_div = 0; m_side = 0; m_lit = 0; m_step = 1'b0; m_l = '0; m_r = '0;
      reset = 1'b1;
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      #1;

      // Left held: 001 at 4, 011 at 8, 111 at 12, 000 at 16, 001 at 20.
      do_reset(1'b1, 1'b0, 1'b0);
      clock_n(3);
      chk("plan_no_step_c3", {2'b00, bus.step}, 3'b000);
      clock_n(1);
      chk("plan_step_c4", {2'b00, bus.step}, 3'b001);
      chk("plan_left_c4", bus.Lcba, 3'b001);
      clock_n(4);  chk("plan_left_c8", bus.Lcba, 3'b011);
      clock_n(4);  chk("plan_left_c12", bus.Lcba, 3'b111);
      clock_n(4);  chk("plan_left_c16", bus.Lcba, 3'b000);
      clock_n(4);  chk("plan_left_c20", bus.Lcba, 3'b001);
      chk("plan_left_rabc", bus.Rabc, 3'b000);

      // Right request dropped at cycle 6: pattern completes, no restart.
      do_reset(1'b0, 1'b1, 1'b0);
      clock_n(6);
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      clock_n(6);  chk("plan_right_c12", bus.Rabc, 3'b111);
      clock_n(8);  chk("plan_right_c20", bus.Rabc, 3'b000);

      // Hazard interrupts a left pattern at L1.
      do_reset(1'b1, 1'b0, 1'b0);
      clock_n(5);
      set_in(1'b1, 1'b0, 1'b1, 1'b0);
      clock_n(3);  chk("plan_haz_c8", bus.Rabc, 3'b111);
      clock_n(4);  chk("plan_haz_c12", bus.Lcba, 3'b000);
      clock_n(4);  chk("plan_haz_c16", bus.Lcba, 3'b111);

      // Left+right together counts as hazard.
      do_reset(1'b1, 1'b1, 1'b0);
      clock_n(4);  chk("plan_lr_c4", bus.Lcba & bus.Rabc, 3'b111);

      // Isolated 1-cycle left pulse between ticks is ignored.
      do_reset(1'b0, 1'b0, 1'b0);
      clock_n(1);
      set_in(1'b1, 1'b0, 1'b0, 1'b0);
      clock_n(1);
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      clock_n(6);  chk("plan_pulse_c8", bus.Lcba | bus.Rabc, 3'b000);

`ifdef TLS_BRAKE_EN
      // Brake in IDLE, then a left turn under brake, then release.
      do_reset(1'b0, 1'b0, 1'b0);
      clock_n(2);
      set_in(1'b0, 1'b0, 1'b0, 1'b1);
      clock_n(1);  chk("plan_brake_idle", bus.Lcba & bus.Rabc, 3'b111);
      set_in(1'b1, 1'b0, 1'b0, 1'b1);
      clock_n(1);  chk("plan_brake_l1_l", bus.Lcba, 3'b001);
      chk("plan_brake_l1_r", bus.Rabc, 3'b111);
      set_in(1'b1, 1'b0, 1'b0, 1'b0);
      clock_n(1);  chk("plan_brake_off", bus.Rabc, 3'b000);
`endif

      // Randomized soak against the model, including mid-sequence resets.
      do_reset(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            bus.left = 1'($urandom);
            bus.right = ($urandom_range(0, 3) == 0);
         end
         if ($urandom_range(0, 15) == 0) bus.hazard = ($urandom_range(0, 2) == 0);
`ifdef TLS_BRAKE_EN
         if ($urandom_range(0, 5) == 0) bus.brake = 1'($urandom);
`endif
         reset = ($urandom_range(0, 199) == 0);
         clock_n(1);
      end
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
